exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 16-bit ASIP pipeline.
- Sits directly downstream of the ID/EXE pipeline register and consumes its outputs: control bits, operands, immediate, alu_op, jump address.
- Performs ADD/SUB/MUL in one cycle and MOD (needed for RSA modular arithmetic) as an iterative restoring divider.
- Registers the result and sideband for the EXE/MEM register, and raises a stall to freeze the front end during MOD.

Parameters:
ARQ, 16, datapath width in bits
JW, 13, jump address width in bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_in  in  1  ID/EXE holds a valid instruction
wb_enable_in  in  1  write-back enable
mem_enable_in  in  1  memory access enable
mux_exe_in  in  1  operand B select: 1=imm_in, 0=src2_in
jop_lsb_in  in  1  conditional jump instruction
src1_in  in  ARQ  operand A
src2_in  in  ARQ  operand B / store data
srcdest_in  in  ARQ  destination register tag
imm_in  in  ARQ  immediate
alu_op_in  in  2  00 ADD, 01 SUB, 10 MUL, 11 MOD
jaddr_in  in  JW  jump target
stall_out  out  1  freeze IF/ID and ID/EXE this cycle
valid_out  out  1  result registers valid
result_out  out  ARQ  ALU result
store_data_out  out  ARQ  registered src2_in
srcdest_out  out  ARQ  registered destination tag
wb_enable_out  out  1  registered write-back enable
mem_enable_out  out  1  registered memory enable
branch_taken_out  out  1  jump taken
branch_addr_out  out  JW  registered jump target

Behaviour:
- Reset (rst=0, asynchronous): every output register is 0, FSM goes to IDLE, iteration counter is 0. stall_out is 0 while in reset.
- opB = mux_exe_in ? imm_in : src2_in.
- FSM states: IDLE, MOD_RUN.
- IDLE, valid_in=0: valid_out<=0 at the next edge. All other output registers hold their values.
- IDLE, valid_in=1, alu_op is not MOD, or MOD with opB==0 — single-cycle path, result at the next edge:
  - valid_out<=1.
  - ADD: result = (src1+opB) mod 2^ARQ.
  - SUB: result = (src1−opB) mod 2^ARQ.
  - MUL: result = low ARQ bits of the product.
  - MOD with opB==0: result = src1_in.
  - Sideband registered: srcdest, wb/mem enables, store_data=src2_in, branch_addr=jaddr_in.
  - branch_taken_out <= jop_lsb_in & (src1_in==opB). It is 0 for non-jump instructions.
- IDLE, valid_in=1, MOD with opB!=0:
  - stall_out=1 combinationally in this cycle.
  - At the edge: latch dividend, divisor and sideband; remainder=0; counter=0; state→MOD_RUN; valid_out<=0.
- MOD_RUN:
  - Each edge performs one restoring step, MSB first: shift the next dividend bit into the remainder, then subtract the divisor if remainder≥divisor. Remainder is ARQ+1 bits wide internally.
  - counter increments each edge.
  - stall_out=1 while counter<ARQ−1. stall_out=0 in the cycle counter==ARQ−1, so upstream advances at that edge.
  - valid_in is ignored throughout MOD_RUN.
  - At the edge with counter==ARQ−1: result<=final remainder, valid_out<=1, latched sideband driven out, branch_taken_out<=0, state→IDLE.
- MOD latency: accept cycle plus ARQ MOD_RUN cycles, so valid_out rises ARQ+1 cycles after acceptance. stall_out is high for exactly ARQ cycles, including the accept cycle.
- valid_out is a one-cycle pulse per accepted instruction. Back-to-back single-cycle ops give a continuous valid_out.
- Reset asserted mid-MOD aborts the operation: all outputs go to 0, state goes to IDLE. No result is produced after reset is released.
- stall_out is purely combinational from state, counter and the current inputs. There is no combinational path from valid_in to any registered output.

Test Plan:
- Reset: rst=0 for 10 cycles with random inputs → all outputs 0 and stall_out 0; release rst → still 0 until the first valid_in.
- Single-cycle ops, src1=152, src2=155, imm=450:
  - ADD, mux=0 → result 307 one cycle later.
  - SUB, mux=1 → result 65238 (wrap-around).
  - MUL with src1=src2=300 → result 24464.
  - Each case: valid_out is a single-cycle pulse; srcdest 170, wb=1, mem=0 are registered through.
- MOD: src1=1254, imm=170, mux=1, alu_op=11 →
  - stall_out high for exactly 16 cycles starting in the accept cycle;
  - valid_out with result 64 on the 17th cycle;
  - an ADD held on the inputs during the MOD is executed exactly once, after the MOD completes.
- MOD by zero: src1=1254, opB=0 → result 1254 next cycle, stall_out never asserts.
- Branch: jop_lsb=1, src1=src2=77, mux=0, jaddr=1254 → branch_taken_out=1, branch_addr_out=1254. With src2=78 → branch_taken_out=0.
- Reset mid-MOD:
  - Assert rst at iteration 8 → outputs 0, stall_out 0, no late valid_out.
  - After release, a new MOD of 1000 by 7 → result 6.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ADD/SUB/MUL in one cycle, MOD as an iterative restoring divider.
// Latency: 1 cycle for ADD/SUB/MUL and MOD-by-zero, ARQ+1 cycles for MOD.
// Backpressure: stall_out freezes IF/ID and ID/EXE for ARQ cycles during MOD.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   valid_in .. jaddr_in     instruction fields from the ID/EXE register
//   stall_out                combinational freeze request to the front end
//   valid_out .. branch_*    registered result and sideband for EXE/MEM
module exe_stage #(
  parameter int ARQ = 16,
  parameter int JW  = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_in,
  input  logic           wb_enable_in,
  input  logic           mem_enable_in,
  input  logic           mux_exe_in,
  input  logic           jop_lsb_in,
  input  logic [ARQ-1:0] src1_in,
  input  logic [ARQ-1:0] src2_in,
  input  logic [ARQ-1:0] srcdest_in,
  input  logic [ARQ-1:0] imm_in,
  input  logic [1:0]     alu_op_in,
  input  logic [JW-1:0]  jaddr_in,
  output logic           stall_out,
  output logic           valid_out,
  output logic [ARQ-1:0] result_out,
  output logic [ARQ-1:0] store_data_out,
  output logic [ARQ-1:0] srcdest_out,
  output logic           wb_enable_out,
  output logic           mem_enable_out,
  output logic           branch_taken_out,
  output logic [JW-1:0]  branch_addr_out
);

  localparam int CW = (ARQ > 1) ? $clog2(ARQ) : 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MOD_RUN = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MOD = 2'b11;

  localparam logic [CW-1:0] LAST = CW'(ARQ - 1);

  logic [0:0]     state_q;
  logic [CW-1:0]  cnt_q;
  logic [ARQ-1:0] dividend_q;
  logic [ARQ-1:0] divisor_q;
  logic [ARQ-1:0] rem_q;

  // Sideband captured at MOD accept, replayed when the remainder is ready.
  logic [ARQ-1:0] sd_q;
  logic [ARQ-1:0] st_q;
  logic [JW-1:0]  ja_q;
  logic           wb_q;
  logic           mem_q;

  logic [ARQ-1:0]   opb;
  logic             mod_start;
  logic [ARQ-1:0]   alu_res;
  logic [2*ARQ-1:0] prod;
  logic [ARQ:0]     rem_shift;
  logic             rem_ge;
  logic [ARQ-1:0]   rem_sub;
  logic [ARQ-1:0]   rem_next;

  assign opb       = mux_exe_in ? imm_in : src2_in;
  assign mod_start = (state_q == IDLE) && valid_in && (alu_op_in == OP_MOD) && (opb != '0);

  // Gated by rst so the front end is never frozen while the stage is held in reset.
  assign stall_out = rst && (mod_start || ((state_q == MOD_RUN) && (cnt_q != LAST)));

  assign prod = {{ARQ{1'b0}}, src1_in} * {{ARQ{1'b0}}, opb};

  always_comb begin
    alu_res = src1_in;
    case (alu_op_in)
      OP_ADD:  alu_res = src1_in + opb;
      OP_SUB:  alu_res = src1_in - opb;
      OP_MUL:  alu_res = prod[ARQ-1:0];
      default: alu_res = src1_in;  // divide by zero returns the dividend
    endcase
  end

  // One restoring step: the shifted partial remainder needs ARQ+1 bits, but
  // after a successful subtract it is below the divisor, so the low ARQ bits
  // of the difference are exact.
  assign rem_shift = {rem_q, dividend_q[ARQ-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor_q};
  assign rem_sub   = rem_shift[ARQ-1:0] - divisor_q;
  assign rem_next  = rem_ge ? rem_sub : rem_shift[ARQ-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      dividend_q       <= '0;
      divisor_q        <= '0;
      rem_q            <= '0;
      sd_q             <= '0;
      st_q             <= '0;
      ja_q             <= '0;
      wb_q             <= 1'b0;
      mem_q            <= 1'b0;
      valid_out        <= 1'b0;
      result_out       <= '0;
      store_data_out   <= '0;
      srcdest_out      <= '0;
      wb_enable_out    <= 1'b0;
      mem_enable_out   <= 1'b0;
      branch_taken_out <= 1'b0;
      branch_addr_out  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!valid_in) begin
            valid_out <= 1'b0;
          end else if (mod_start) begin
            dividend_q <= src1_in;
            divisor_q  <= opb;
            rem_q      <= '0;
            cnt_q      <= '0;
            sd_q       <= srcdest_in;
            st_q       <= src2_in;
            ja_q       <= jaddr_in;
            wb_q       <= wb_enable_in;
            mem_q      <= mem_enable_in;
            valid_out  <= 1'b0;
            state_q    <= MOD_RUN;
          end else begin
            valid_out        <= 1'b1;
            result_out       <= alu_res;
            store_data_out   <= src2_in;
            srcdest_out      <= srcdest_in;
            wb_enable_out    <= wb_enable_in;
            mem_enable_out   <= mem_enable_in;
            branch_taken_out <= jop_lsb_in && (src1_in == opb);
            branch_addr_out  <= jaddr_in;
          end
        end
        default: begin
          dividend_q <= dividend_q << 1;
          rem_q      <= rem_next;
          cnt_q      <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            valid_out        <= 1'b1;
            result_out       <= rem_next;
            store_data_out   <= st_q;
            srcdest_out      <= sd_q;
            wb_enable_out    <= wb_q;
            mem_enable_out   <= mem_q;
            branch_taken_out <= 1'b0;
            branch_addr_out  <= ja_q;
            state_q          <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases followed by randomized instructions.
// Upstream is modelled as a pipeline register that advances only on edges where
// stall_out was low; each consumed instruction's result is expected one edge later.
module tb_exe_stage;

  localparam int ARQ = 16;
  localparam int JW  = 13;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_in;
  logic           wb_enable_in;
  logic           mem_enable_in;
  logic           mux_exe_in;
  logic           jop_lsb_in;
  logic [ARQ-1:0] src1_in;
  logic [ARQ-1:0] src2_in;
  logic [ARQ-1:0] srcdest_in;
  logic [ARQ-1:0] imm_in;
  logic [1:0]     alu_op_in;
  logic [JW-1:0]  jaddr_in;
  logic           stall_out;
  logic           valid_out;
  logic [ARQ-1:0] result_out;
  logic [ARQ-1:0] store_data_out;
  logic [ARQ-1:0] srcdest_out;
  logic           wb_enable_out;
  logic           mem_enable_out;
  logic           branch_taken_out;
  logic [JW-1:0]  branch_addr_out;

  exe_stage #(.ARQ(ARQ), .JW(JW)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .wb_enable_in     (wb_enable_in),
    .mem_enable_in    (mem_enable_in),
    .mux_exe_in       (mux_exe_in),
    .jop_lsb_in       (jop_lsb_in),
    .src1_in          (src1_in),
    .src2_in          (src2_in),
    .srcdest_in       (srcdest_in),
    .imm_in           (imm_in),
    .alu_op_in        (alu_op_in),
    .jaddr_in         (jaddr_in),
    .stall_out        (stall_out),
    .valid_out        (valid_out),
    .result_out       (result_out),
    .store_data_out   (store_data_out),
    .srcdest_out      (srcdest_out),
    .wb_enable_out    (wb_enable_out),
    .mem_enable_out   (mem_enable_out),
    .branch_taken_out (branch_taken_out),
    .branch_addr_out  (branch_addr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]     op;
    logic           mux;
    logic           jop;
    logic           wb;
    logic           mem;
    logic [ARQ-1:0] a;
    logic [ARQ-1:0] b;
    logic [ARQ-1:0] imm;
    logic [ARQ-1:0] sd;
    logic [JW-1:0]  ja;
  } ins_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference copy of the output registers
  logic [ARQ-1:0] e_res, e_st, e_sd;
  logic [JW-1:0]  e_ba;
  logic           e_wb, e_mem, e_bt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_vld);
    chk({tag, "_valid"},  32'(valid_out),        32'(exp_vld));
    chk({tag, "_result"}, 32'(result_out),       32'(e_res));
    chk({tag, "_store"},  32'(store_data_out),   32'(e_st));
    chk({tag, "_dest"},   32'(srcdest_out),      32'(e_sd));
    chk({tag, "_wb"},     32'(wb_enable_out),    32'(e_wb));
    chk({tag, "_mem"},    32'(mem_enable_out),   32'(e_mem));
    chk({tag, "_btaken"}, 32'(branch_taken_out), 32'(e_bt));
    chk({tag, "_baddr"},  32'(branch_addr_out),  32'(e_ba));
  endtask

  task automatic clear_model();
    e_res = '0; e_st = '0; e_sd = '0; e_ba = '0;
    e_wb = 1'b0; e_mem = 1'b0; e_bt = 1'b0;
  endtask

  // Architectural meaning of one instruction, straight from the ISA rules.
  task automatic model(input ins_t i);
    logic [ARQ-1:0] ob;
    ob = i.mux ? i.imm : i.b;
    case (i.op)
      2'd0:    e_res = i.a + ob;
      2'd1:    e_res = i.a - ob;
      2'd2:    e_res = 16'((32'(i.a) * 32'(ob)) % 32'h10000);
      default: e_res = (ob == 0) ? i.a : 16'(32'(i.a) % 32'(ob));
    endcase
    e_bt  = (i.op == 2'd3 && ob != 0) ? 1'b0 : (i.jop && (i.a == ob));
    e_st  = i.b;
    e_sd  = i.sd;
    e_ba  = i.ja;
    e_wb  = i.wb;
    e_mem = i.mem;
  endtask

  task automatic drive(input ins_t i, input logic vld);
    valid_in      = vld;
    alu_op_in     = i.op;
    mux_exe_in    = i.mux;
    jop_lsb_in    = i.jop;
    wb_enable_in  = i.wb;
    mem_enable_in = i.mem;
    src1_in       = i.a;
    src2_in       = i.b;
    imm_in        = i.imm;
    srcdest_in    = i.sd;
    jaddr_in      = i.ja;
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    i.op  = 2'($urandom_range(0, 3));
    i.mux = 1'($urandom);
    i.jop = 1'($urandom);
    i.wb  = 1'($urandom);
    i.mem = 1'($urandom);
    i.a   = 16'($urandom);
    i.b   = 16'($urandom);
    i.imm = 16'($urandom);
    i.sd  = 16'($urandom);
    i.ja  = 13'($urandom);
    return i;
  endfunction

  // Called at posedge+1: holds the instruction until an edge where stall_out
  // was low, then checks the registered outputs one edge later.
  task automatic issue(input string tag, input ins_t i, output int stalls);
    logic s;
    logic done;
    drive(i, 1'b1);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      s = stall_out;
      if (stalls > 0) chk({tag, "_busy_valid"}, 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
      if (!s) done = 1'b1;
      else stalls++;
    end
    chk({tag, "_consumed"}, 32'(done), 32'd1);
    model(i);
    check_outputs(tag, 1'b1);
  endtask

  task automatic idle(input int n);
    ins_t r;
    for (int k = 0; k < n; k++) begin
      r = rand_ins();
      drive(r, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("idle", 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t i;
    int   st;

    // ---- reset with random inputs ----
    rst = 1'b0;
    clear_model();
    for (int k = 0; k < 10; k++) begin
      drive(rand_ins(), 1'($urandom));
      @(posedge clk);
      #1;
      check_outputs("reset", 1'b0);
      chk("reset_stall", 32'(stall_out), 32'd0);
    end
    rst = 1'b1;
    idle(3);

    // ---- directed single-cycle ops ----
    i = '0;
    i.a = 16'd152; i.b = 16'd155; i.imm = 16'd450; i.sd = 16'd170; i.wb = 1'b1;
    i.op = 2'd0; i.mux = 1'b0;
    issue("add", i, st);
    chk("add_literal", 32'(result_out), 32'd307);
    chk("add_stall", 32'(st), 32'd0);
    idle(1);
    i.op = 2'd1; i.mux = 1'b1;
    issue("sub", i, st);
    chk("sub_literal", 32'(result_out), 32'd65238);
    idle(1);
    i.op = 2'd2; i.mux = 1'b0; i.a = 16'd300; i.b = 16'd300;
    issue("mul", i, st);
    chk("mul_literal", 32'(result_out), 32'd24464);
    chk("mul_dest", 32'(srcdest_out), 32'd170);
    idle(1);

    // ---- MOD followed by an ADD waiting upstream ----
    i = '0;
    i.a = 16'd1254; i.imm = 16'd170; i.b = 16'd9; i.mux = 1'b1; i.op = 2'd3;
    i.sd = 16'd170; i.wb = 1'b1; i.ja = 13'd33;
    issue("mod", i, st);
    chk("mod_literal", 32'(result_out), 32'd64);
    chk("mod_stall_cycles", 32'(st), 32'd16);
    i = '0;
    i.a = 16'd152; i.b = 16'd155; i.op = 2'd0; i.sd = 16'd5;
    issue("add_after_mod", i, st);
    chk("add_after_mod_literal", 32'(result_out), 32'd307);
    idle(2);

    // ---- MOD by zero ----
    i = '0;
    i.a = 16'd1254; i.imm = 16'd0; i.b = 16'd4; i.mux = 1'b1; i.op = 2'd3;
    issue("mod0", i, st);
    chk("mod0_literal", 32'(result_out), 32'd1254);
    chk("mod0_stall", 32'(st), 32'd0);
    idle(1);

    // ---- branch compare ----
    i = '0;
    i.a = 16'd77; i.b = 16'd77; i.jop = 1'b1; i.ja = 13'd1254; i.op = 2'd1;
    issue("br_taken", i, st);
    chk("br_taken_literal", 32'(branch_taken_out), 32'd1);
    chk("br_addr_literal", 32'(branch_addr_out), 32'd1254);
    i.b = 16'd78;
    issue("br_not", i, st);
    chk("br_not_literal", 32'(branch_taken_out), 32'd0);

    // ---- back-to-back single-cycle ops keep valid_out high ----
    for (int k = 0; k < 6; k++) begin
      i = rand_ins();
      i.op = 2'($urandom_range(0, 2));
      issue("b2b", i, st);
    end
    idle(1);

    // ---- reset in the middle of a MOD ----
    i = '0;
    i.a = 16'd50000; i.imm = 16'd13; i.mux = 1'b1; i.op = 2'd3; i.wb = 1'b1; i.sd = 16'd3;
    drive(i, 1'b1);
    @(negedge clk);
    chk("midrst_accept_stall", 32'(stall_out), 32'd1);
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_busy_stall", 32'(stall_out), 32'd1);
    rst = 1'b0;
    #1;
    clear_model();
    check_outputs("midrst", 1'b0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    drive(rand_ins(), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("midrst_hold", 1'b0);
    rst = 1'b1;
    idle(20);
    i = '0;
    i.a = 16'd1000; i.b = 16'd7; i.mux = 1'b0; i.op = 2'd3;
    issue("mod_after_rst", i, st);
    chk("mod_after_rst_literal", 32'(result_out), 32'd6);
    chk("mod_after_rst_stall", 32'(st), 32'd16);

    // ---- randomized mix against the reference model ----
    for (int k = 0; k < 150; k++) begin
      i = rand_ins();
      if ($urandom_range(0, 7) == 0) begin
        if (i.mux) i.imm = '0;
        else i.b = '0;
      end
      if ($urandom_range(0, 7) == 0) i.a = i.mux ? i.imm : i.b;
      issue("rand", i, st);
      chk("rand_stall_cycles", 32'(st),
          32'((i.op == 2'd3 && (i.mux ? i.imm : i.b) != 0) ? ARQ : 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
